// File: rtl/conv33_stream_ctrl_if.sv
// Stream control bundle between the conv33 sequencer (master) and the
// line-buffer/compute datapath it drives (slave).
interface conv33_stream_ctrl_if #(
  parameter int CW = 16
);
  logic          start;
  logic          in_inst_input_read_valid;
  logic          out_inst_output_write_en;
  logic [CW-1:0] out_x;
  logic [CW-1:0] out_y;
  logic          busy;
  logic          done;

  modport master (
    input  start,
    output in_inst_input_read_valid, out_inst_output_write_en,
    output out_x, out_y, busy, done
  );

  modport slave (
    output start,
    input  in_inst_input_read_valid, out_inst_output_write_en,
    input  out_x, out_y, busy, done
  );
endinterface

// File: rtl/conv33_stream_ctrl.sv
// Frame sequencer for the 3x3 convolution: streams IMG_W*IMG_H read strobes and
// raises write_en when a full 9-tap window reaches the compute unit.
module conv33_stream_ctrl #(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int IN_LAT = 1,
  parameter int CW     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  conv33_stream_ctrl_if.master bus
);

  if (IMG_W < 3 || IMG_H < 3 || IN_LAT < 1 || IN_LAT > 8) begin : g_cfg_err
    $error("conv33_stream_ctrl: IMG_W/IMG_H must be >= 3 and IN_LAT in 1..8");
  end

  localparam logic [CW-1:0] W_LAST   = CW'(IMG_W - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(IMG_H - 1);
  localparam logic [3:0]    LAT_LAST = 4'(IN_LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE} state_e;

  typedef struct packed {
    logic          v;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
  } tap_t;

  state_e        state_q, state_d;
  logic [CW-1:0] col_q, col_d, row_q, row_d;
  logic [3:0]    drn_q, drn_d;
  logic          last_px;
  tap_t          tap0;
  tap_t [IN_LAT-1:0] pipe_q;

  assign last_px = (col_q == W_LAST) && (row_q == H_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      drn_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      drn_q   <= drn_d;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    drn_d   = drn_q;
    unique case (state_q)
      S_IDLE: begin
        col_d = '0;
        row_d = '0;
        if (bus.start) state_d = S_STREAM;
      end
      S_STREAM: begin
        if (last_px) begin
          col_d   = '0;
          row_d   = '0;
          drn_d   = '0;
          state_d = S_DRAIN;
        end else if (col_q == W_LAST) begin
          col_d = '0;
          row_d = row_q + CW'(1);
        end else begin
          col_d = col_q + CW'(1);
        end
      end
      S_DRAIN: begin
        if (drn_q == LAT_LAST) state_d = S_DONE;
        else                   drn_d   = drn_q + 4'd1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // A window is complete once the pixel being read sits at row>=2, col>=2;
  // its top-left coordinate then travels with it through the input latency.
  always_comb begin
    tap0   = '0;
    tap0.v = (state_q == S_STREAM) && (row_q >= CW'(2)) && (col_q >= CW'(2));
    if (tap0.v) begin
      tap0.x = col_q - CW'(2);
      tap0.y = row_q - CW'(2);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= tap0;
      for (int i = 1; i < IN_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  always_comb begin
    bus.in_inst_input_read_valid = (state_q == S_STREAM);
    bus.busy                     = (state_q == S_STREAM) || (state_q == S_DRAIN);
    bus.done                     = (state_q == S_DONE);
    bus.out_inst_output_write_en = pipe_q[IN_LAT-1].v;
    bus.out_x                    = pipe_q[IN_LAT-1].x;
    bus.out_y                    = pipe_q[IN_LAT-1].y;
  end

endmodule

// File: tb/tb_conv33_stream_ctrl.sv
// Directed + randomized frame checks of conv33_stream_ctrl against a cycle
// formula model, across several image/latency configurations.
module tb_conv33_stream_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] start_v = '0;
  int         ncmp = 0;
  int         nfail = 0;

  always #5 clk = ~clk;

  conv33_stream_ctrl_if #(.CW(16)) if0 ();
  conv33_stream_ctrl_if #(.CW(16)) if1 ();
  conv33_stream_ctrl_if #(.CW(16)) if2 ();
  conv33_stream_ctrl_if #(.CW(16)) if3 ();

  assign if0.start = start_v[0];
  assign if1.start = start_v[1];
  assign if2.start = start_v[2];
  assign if3.start = start_v[3];

  conv33_stream_ctrl #(.IMG_W(4),  .IMG_H(4),  .IN_LAT(1), .CW(16)) u_a (.clk(clk), .reset(reset), .bus(if0));
  conv33_stream_ctrl #(.IMG_W(4),  .IMG_H(4),  .IN_LAT(3), .CW(16)) u_b (.clk(clk), .reset(reset), .bus(if1));
  conv33_stream_ctrl #(.IMG_W(8),  .IMG_H(3),  .IN_LAT(1), .CW(16)) u_c (.clk(clk), .reset(reset), .bus(if2));
  conv33_stream_ctrl #(.IMG_W(64), .IMG_H(64), .IN_LAT(1), .CW(16)) u_d (.clk(clk), .reset(reset), .bus(if3));

  typedef struct packed {
    logic        rv;
    logic        we;
    logic        busy;
    logic        done;
    logic [15:0] x;
    logic [15:0] y;
  } obs_t;

  obs_t obs [4];
  assign obs[0] = '{if0.in_inst_input_read_valid, if0.out_inst_output_write_en, if0.busy, if0.done, if0.out_x, if0.out_y};
  assign obs[1] = '{if1.in_inst_input_read_valid, if1.out_inst_output_write_en, if1.busy, if1.done, if1.out_x, if1.out_y};
  assign obs[2] = '{if2.in_inst_input_read_valid, if2.out_inst_output_write_en, if2.busy, if2.done, if2.out_x, if2.out_y};
  assign obs[3] = '{if3.in_inst_input_read_valid, if3.out_inst_output_write_en, if3.busy, if3.done, if3.out_x, if3.out_y};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Expected outputs in cycle k of a frame whose start was sampled at edge 0.
  function automatic obs_t model(input int W, input int H, input int L, input int k);
    obs_t m;
    int   n, p;
    n      = W * H;
    m      = '0;
    m.rv   = (k >= 1) && (k <= n);
    m.busy = (k >= 1) && (k <= n + L);
    m.done = (k == n + L + 1);
    p      = k - 1 - L;
    if (p >= 0 && p < n && (p / W) >= 2 && (p % W) >= 2) begin
      m.we = 1'b1;
      m.x  = 16'(p % W - 2);
      m.y  = 16'(p / W - 2);
    end
    return m;
  endfunction

  task automatic run_frame(input int sel, input int W, input int H, input int L,
                           input int sp0, input int sp1, input int abort_k);
    obs_t o, e;
    int   n, npulse, ndone, maxx, maxy;
    n = W * H; npulse = 0; ndone = 0; maxx = 0; maxy = 0;
    @(posedge clk); #1;
    start_v[sel] = 1'b1;
    for (int k = 1; k <= n + L + 4; k++) begin
      @(posedge clk); #1;
      start_v[sel] = (k == sp0) || (k == sp1);
      if (k == abort_k) begin
        start_v[sel] = 1'b0;
        #2 reset = 1'b0;
        #1 chk("abort_async", 32'(obs[sel]), 32'(0));
        for (int j = 0; j < n + L + 2; j++) begin
          @(posedge clk); #1;
          chk("abort_held", 32'(obs[sel]), 32'(0));
        end
        reset = 1'b1;
        for (int j = 0; j < 3; j++) begin
          @(posedge clk); #1;
          chk("abort_after", 32'(obs[sel]), 32'(0));
        end
        return;
      end
      o = obs[sel];
      e = model(W, H, L, k);
      chk("read_valid", 32'(o.rv), 32'(e.rv));
      chk("busy", 32'(o.busy), 32'(e.busy));
      chk("done", 32'(o.done), 32'(e.done));
      chk("write_en", 32'(o.we), 32'(e.we));
      chk("out_x", 32'(o.x), 32'(e.x));
      chk("out_y", 32'(o.y), 32'(e.y));
      if (o.we === 1'b1) begin
        npulse++;
        if (int'(o.x) > maxx) maxx = int'(o.x);
        if (int'(o.y) > maxy) maxy = int'(o.y);
      end
      if (o.done === 1'b1) ndone++;
    end
    start_v[sel] = 1'b0;
    chk("pulse_count", 32'(npulse), 32'((W - 2) * (H - 2)));
    chk("done_count", 32'(ndone), 32'(1));
    chk("max_x", 32'(maxx), 32'(W - 3));
    chk("max_y", 32'(maxy), 32'(H - 3));
  endtask

  initial begin
    int sel, w, h, l, n, s0, s1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) chk("reset_state", 32'(obs[i]), 32'(0));
    reset = 1'b1;
    repeat (2) @(posedge clk);

    run_frame(0, 4, 4, 1, 0, 0, 0);
    run_frame(1, 4, 4, 3, 0, 0, 0);
    run_frame(0, 4, 4, 1, 5, 17, 0);
    run_frame(0, 4, 4, 1, 0, 0, 0);
    run_frame(0, 4, 4, 1, 0, 0, 13);
    run_frame(0, 4, 4, 1, 0, 0, 0);
    run_frame(2, 8, 3, 1, 0, 0, 0);
    run_frame(3, 64, 64, 1, 0, 0, 0);

    for (int it = 0; it < 8; it++) begin
      sel = int'($urandom_range(0, 2));
      case (sel)
        0:       begin w = 4; h = 4; l = 1; end
        1:       begin w = 4; h = 4; l = 3; end
        default: begin w = 8; h = 3; l = 1; end
      endcase
      n  = w * h;
      s0 = int'($urandom_range(1, n + l + 1));
      s1 = int'($urandom_range(1, n + l + 1));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      run_frame(sel, w, h, l, s0, s1, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
